reflet_uart_rx_fifo: RTL

//  Memory-mapped UART receiver with an 8-byte receive FIFO. It is the receive-side

---
 rtl/reflet_uart_rx_fifo.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/reflet_uart_rx_fifo.sv
// Memory-mapped 8N1 UART receiver with a power-of-two receive FIFO.
// Three bus registers: data/pop, status/W1C, occupancy; reads are combinational and OR-safe.
module reflet_uart_rx_fifo #(
  parameter int base_addr_size  = 15,
  parameter int base_addr       = 0,
  parameter int clk_freq        = 96000,
  parameter int baud_rate       = 9600,
  parameter int fifo_depth_log2 = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  input  logic                      rx
);

  localparam int DIV   = clk_freq / baud_rate;
  localparam int DEPTH = 2 ** fifo_depth_log2;
  localparam int CNT_W = $clog2(DIV);
  localparam int PW    = fifo_depth_log2;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
  localparam logic [PW:0]      DEPTH_C  = (PW + 1)'(DEPTH);

  localparam logic [base_addr_size-1:0] A0 = base_addr_size'(base_addr);
  localparam logic [base_addr_size-1:0] A1 = base_addr_size'(base_addr + 1);
  localparam logic [base_addr_size-1:0] A2 = base_addr_size'(base_addr + 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             rx_meta_q, rx_s_q;

  logic [7:0]       mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q, count_d;
  logic             overflow_q, frame_err_q;

  logic hit0, hit1, hit2;
  logic cnt_zero, push, ferr_set, full, not_empty, pop, push_ok, ovf_set;
  logic unused_data;

  assign hit0 = enable && (addr == A0);
  assign hit1 = enable && (addr == A1);
  assign hit2 = enable && (addr == A2);

  assign cnt_zero  = (cnt_q == '0);
  assign push      = (state_q == S_STOP) && cnt_zero && rx_s_q;
  assign ferr_set  = (state_q == S_STOP) && cnt_zero && !rx_s_q;
  assign full      = (count_q == DEPTH_C);
  assign not_empty = (count_q != '0);
  assign pop       = hit0 && write_en && not_empty;
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign push_ok   = push && (!full || pop);
  assign ovf_set   = push && full && !pop;

  assign unused_data = ^{data_in[7:4], data_in[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            cnt_q   <= CNT_HALF;
          end
        end
        S_START: begin
          if (!cnt_zero) cnt_q <= cnt_q - 1'b1;
          else if (rx_s_q) state_q <= S_IDLE;
          else begin
            state_q <= S_DATA;
            cnt_q   <= CNT_FULL;
            bit_q   <= '0;
          end
        end
        S_DATA: begin
          if (!cnt_zero) cnt_q <= cnt_q - 1'b1;
          else begin
            shift_q <= {rx_s_q, shift_q[7:1]};
            cnt_q   <= CNT_FULL;
            if (bit_q == 3'd7) state_q <= S_STOP;
            else bit_q <= bit_q + 1'b1;
          end
        end
        S_STOP: begin
          if (!cnt_zero) cnt_q <= cnt_q - 1'b1;
          else state_q <= rx_s_q ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  // Flags are sticky; a set on the same edge as a W1C clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      overflow_q  <= ovf_set  | (overflow_q  & ~(hit1 & write_en & data_in[2]));
      frame_err_q <= ferr_set | (frame_err_q & ~(hit1 & write_en & data_in[3]));
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (hit0)      data_out = not_empty ? mem_q[rd_ptr_q] : 8'h00;
    else if (hit1) data_out = {4'b0, frame_err_q, overflow_q, full, not_empty};
    else if (hit2) data_out = 8'(count_q);
  end

endmodule
